// File: rtl/dose_scheduler_if.sv
// Signal bundle between the dose scheduler and its surroundings: buttons, tick, ROM, displays.
// The master side is the environment; the slave side is the scheduler itself.
interface dose_scheduler_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  pause;
  logic                  ack;
  logic                  tick;
  logic [7:0]            romContent;
  logic [ADDR_WIDTH-1:0] romAddress;
  logic [3:0]            currentId;
  logic [3:0]            unitsLeft;
  logic                  alarm;
  logic                  busy;
  logic                  paused;
  logic                  scheduleDone;
  logic [3:0]            takenCount;
  logic [3:0]            missedCount;

  modport master (
    output start, pause, ack, tick, romContent,
    input  romAddress, currentId, unitsLeft, alarm, busy, paused,
           scheduleDone, takenCount, missedCount
  );

  modport slave (
    input  start, pause, ack, tick, romContent,
    output romAddress, currentId, unitsLeft, alarm, busy, paused,
           scheduleDone, takenCount, missedCount
  );
endinterface

// File: rtl/dose_scheduler.sv
// Walks the prescription ROM one entry per dose: count the interval down on the
// one-second tick, then hold the dose alarm until it is acknowledged or times out.
module dose_scheduler #(
  parameter int ADDR_WIDTH     = 8,
  parameter int BASE_ADDR      = 0,
  parameter int MAX_ENTRIES    = 16,
  parameter int TICKS_PER_UNIT = 60,
  parameter int ALARM_TIMEOUT  = 30
) (
  input  logic             clk,
  input  logic             reset,
  dose_scheduler_if.slave  bus
);

  localparam int EW = ADDR_WIDTH + 1;
  localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int AW = (ALARM_TIMEOUT > 1) ? $clog2(ALARM_TIMEOUT) : 1;

  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [EW-1:0]         ENTRY_LIM  = EW'(MAX_ENTRIES);
  localparam logic [TW-1:0]         TICK_LAST  = TW'(TICKS_PER_UNIT - 1);
  localparam logic [AW-1:0]         ALARM_LAST = AW'(ALARM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ROMWAIT, S_LOAD, S_COUNT, S_PAUSED, S_ALARM, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [EW-1:0]         entry_q, entry_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [AW-1:0]         acnt_q, acnt_d;
  logic [3:0]            id_q, id_d;
  logic [3:0]            units_q, units_d;
  logic [3:0]            taken_q, taken_d;
  logic [3:0]            missed_q, missed_d;
  logic                  alarm_q, alarm_d;
  logic                  busy_q, busy_d;
  logic                  paused_q, paused_d;
  logic                  done_q, done_d;
  logic                  adv;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    entry_d  = entry_q;
    tick_d   = tick_q;
    acnt_d   = acnt_q;
    id_d     = id_q;
    units_d  = units_q;
    taken_d  = taken_q;
    missed_d = missed_q;
    adv      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          taken_d  = '0;
          missed_d = '0;
          entry_d  = '0;
          addr_d   = BASE;
          state_d  = S_FETCH;
        end
      end
      S_FETCH:   state_d = S_ROMWAIT;
      S_ROMWAIT: state_d = S_LOAD;
      S_LOAD: begin
        // An all-zero byte terminates the schedule; so does the entry limit.
        if (bus.romContent == 8'h00 || entry_q == ENTRY_LIM) begin
          state_d = S_DONE;
        end else begin
          id_d    = bus.romContent[7:4];
          units_d = bus.romContent[3:0];
          tick_d  = '0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (units_q == 4'd0) begin
          acnt_d  = '0;
          state_d = S_ALARM;
        end else if (bus.pause) begin
          state_d = S_PAUSED;
        end else if (bus.tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            units_d = units_q - 4'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_PAUSED: begin
        if (bus.pause || bus.start) state_d = S_COUNT;
      end
      S_ALARM: begin
        // ack takes priority over a coinciding timeout tick.
        if (bus.ack) begin
          taken_d = sat_inc(taken_q);
          adv     = 1'b1;
        end else if (bus.tick) begin
          if (acnt_q == ALARM_LAST) begin
            missed_d = sat_inc(missed_q);
            adv      = 1'b1;
          end else begin
            acnt_d = acnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      entry_d = entry_q + 1'b1;
      addr_d  = addr_q + 1'b1;
      state_d = S_FETCH;
    end
  end

  // Status flags are registered from the next state so they change with it.
  assign alarm_d  = (state_d == S_ALARM);
  assign busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
  assign paused_d = (state_d == S_PAUSED);
  assign done_d   = (state_d == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= BASE;
      entry_q  <= '0;
      tick_q   <= '0;
      acnt_q   <= '0;
      id_q     <= '0;
      units_q  <= '0;
      taken_q  <= '0;
      missed_q <= '0;
      alarm_q  <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      entry_q  <= entry_d;
      tick_q   <= tick_d;
      acnt_q   <= acnt_d;
      id_q     <= id_d;
      units_q  <= units_d;
      taken_q  <= taken_d;
      missed_q <= missed_d;
      alarm_q  <= alarm_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  assign bus.romAddress   = addr_q;
  assign bus.currentId    = id_q;
  assign bus.unitsLeft    = units_q;
  assign bus.alarm        = alarm_q;
  assign bus.busy         = busy_q;
  assign bus.paused       = paused_q;
  assign bus.scheduleDone = done_q;
  assign bus.takenCount   = taken_q;
  assign bus.missedCount  = missed_q;

endmodule
